muldiv_unit: RTL

- Iterative RV32M multiply/divide execution unit.
- Consumes the two source-operand read ports of the register file (rs1/rs2 values) and produces a 32-bit result for the register write-back data path.
- Multi-cycle, with a start/busy/done handshake; the core control stalls the PC and holds RegWrite low while busy is high.

---
 rtl/muldiv_unit_if.sv | 22 ++
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake and operand bus between the core and the iterative multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, funct3, rs1_val, rs2_val,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, sign-corrected in the final cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
    state_t state, state_next;

    logic [2:0]         op;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH:0]     rem;
    logic               neg_res;
    logic               neg_rem;
    logic               special;
    logic [WIDTH-1:0]   special_res;

    logic               sign_a, sign_b, a_neg, b_neg;
    logic               div_zero, div_ovf;
    logic [WIDTH-1:0]   a_mag, b_mag, special_val;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_shift, div_trial;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, final_res;

    // MUL is treated as unsigned since the low product bits do not depend on signedness.
    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (bus.funct3)
            3'b001, 3'b100, 3'b110: begin
                sign_a = 1'b1;
                sign_b = 1'b1;
            end
            3'b010:  sign_a = 1'b1;
            default: ;
        endcase
        a_neg    = sign_a & bus.rs1_val[WIDTH-1];
        b_neg    = sign_b & bus.rs2_val[WIDTH-1];
        a_mag    = a_neg ? -bus.rs1_val : bus.rs1_val;
        b_mag    = b_neg ? -bus.rs2_val : bus.rs2_val;
        div_zero = bus.funct3[2] && (bus.rs2_val == '0);
        div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                   (bus.rs1_val == MIN_NEG) && (bus.rs2_val == '1);
        special_val = '0;
        if (div_zero)
            special_val = bus.funct3[1] ? bus.rs1_val : '1;
        else if (div_ovf)
            special_val = bus.funct3[1] ? '0 : MIN_NEG;
    end

    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_trial = div_shift - {2'b00, divisor};

    always_comb begin
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = neg_res ? -quo : quo;
        rem_fix  = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        case (op)
            3'b000:                 final_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus.busy   = (state != IDLE);
        case (state)
            IDLE:    if (bus.start) state_next = (div_zero || div_ovf) ? FINISH : CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The quotient shifts in where the dividend shifts out, so one register serves both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op          <= '0;
            cnt         <= '0;
            prod        <= '0;
            mcand       <= '0;
            divisor     <= '0;
            quo         <= '0;
            rem         <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            special     <= 1'b0;
            special_res <= '0;
            bus.done    <= 1'b0;
            bus.result  <= '0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE && bus.start) begin
                op          <= bus.funct3;
                cnt         <= '0;
                prod        <= {{WIDTH{1'b0}}, b_mag};
                mcand       <= a_mag;
                divisor     <= b_mag;
                quo         <= a_mag;
                rem         <= '0;
                neg_res     <= a_neg ^ b_neg;
                neg_rem     <= a_neg;
                special     <= div_zero || div_ovf;
                special_res <= special_val;
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                if (!op[2]) begin
                    prod <= {mul_sum, prod[WIDTH-1:1]};
                end else if (!div_trial[WIDTH+1]) begin
                    rem <= div_trial[WIDTH:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= div_shift[WIDTH:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
            end else if (state == FINISH) begin
                bus.result <= special ? special_res : final_res;
                bus.done   <= 1'b1;
            end
        end
    end
endmodule
